// File: rtl/v_pipe_update_exe.sv
// Execute stage of the table-update pipeline: applies commands to the sorted table and returns responses/dumps.
// Optional feature: define V_PIPE_UPDATE_EXE_SAT_EN to saturate ADD-hit volumes instead of wrapping.
module v_pipe_update_exe #(
    parameter int ENTRIES_N    = 16,
    parameter int KEY_BITS     = 32,
    parameter int VOLUME_BITS  = 32,
    parameter int IS_BID_TABLE = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_cmd_vld,
    output logic                             o_cmd_rdy,
    input  logic [2:0]                       i_cmd_opcode,
    input  logic [KEY_BITS-1:0]              i_cmd_key,
    input  logic [VOLUME_BITS-1:0]           i_cmd_volume,
    input  logic                             i_match_hit,
    input  logic                             i_match_full,
    input  logic [ENTRIES_N-1:0]             i_match_sel,
    input  logic [ENTRIES_N-1:0]             i_mask_cmp,
    output logic [ENTRIES_N-1:0]             o_stcur_vld_r,
    output logic [ENTRIES_N*KEY_BITS-1:0]    o_stcur_keys_r,
    output logic [ENTRIES_N*VOLUME_BITS-1:0] o_stcur_volumes_r,
    output logic                             o_rsp_vld_r,
    input  logic                             i_rsp_rdy,
    output logic [1:0]                       o_rsp_status_r,
    output logic [KEY_BITS-1:0]              o_rsp_key_r,
    output logic [VOLUME_BITS-1:0]           o_rsp_volume_r,
    output logic                             o_rsp_last_r
);
    localparam int IDX_W = $clog2(ENTRIES_N);
    localparam int CNT_W = $clog2(ENTRIES_N + 1);

    localparam logic [2:0] OP_NOP = 3'd0, OP_CLR = 3'd1, OP_ADD = 3'd2;
    localparam logic [2:0] OP_DEL = 3'd3, OP_REP = 3'd4, OP_QRY = 3'd5;
    localparam logic [1:0] ST_OK = 2'd0, ST_FULL = 2'd1, ST_NOTFOUND = 2'd2, ST_BADOP = 2'd3;

    // Sort direction is resolved by the compare stage; only legal values are accepted here.
    if (IS_BID_TABLE != 0 && IS_BID_TABLE != 1) begin : g_bad_cfg
        $error("IS_BID_TABLE must be 0 or 1");
    end

    typedef enum logic {S_IDLE, S_DUMP} state_t;
    state_t state_q, state_d;

    logic [ENTRIES_N-1:0]   vld_q, vld_d;
    logic [KEY_BITS-1:0]    keys_q [ENTRIES_N];
    logic [KEY_BITS-1:0]    keys_d [ENTRIES_N];
    logic [VOLUME_BITS-1:0] vols_q [ENTRIES_N];
    logic [VOLUME_BITS-1:0] vols_d [ENTRIES_N];
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   rsp_vld_q, rsp_vld_d, rsp_last_q, rsp_last_d;
    logic [1:0]             rsp_status_q, rsp_status_d;
    logic [KEY_BITS-1:0]    rsp_key_q, rsp_key_d;
    logic [VOLUME_BITS-1:0] rsp_vol_q, rsp_vol_d;

    logic                   cmd_acc, rsp_hs;
    logic [CNT_W-1:0]       ins_pos, nxt_idx;
    logic [IDX_W-1:0]       del_pos;
    logic [VOLUME_BITS-1:0] hit_vol, new_vol;
    logic [ENTRIES_N:0]     vld_ext;

    function automatic logic [VOLUME_BITS-1:0] add_vol(input logic [VOLUME_BITS-1:0] a,
                                                       input logic [VOLUME_BITS-1:0] b);
`ifdef V_PIPE_UPDATE_EXE_SAT_EN
        logic [VOLUME_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[VOLUME_BITS] ? {VOLUME_BITS{1'b1}} : s[VOLUME_BITS-1:0];
`else
        return a + b;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_acc && i_cmd_opcode == OP_QRY && vld_q[0]) state_d = S_DUMP;
            S_DUMP:  if (rsp_hs && rsp_last_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_cmd_rdy = (state_q == S_IDLE) && !rst && (!rsp_vld_q || i_rsp_rdy);
        cmd_acc   = i_cmd_vld && o_cmd_rdy;
        rsp_hs    = rsp_vld_q && i_rsp_rdy;
    end

    // Insert position, delete index and the hit entry's volume are decoded from the compare-stage vectors.
    always_comb begin
        ins_pos = '0;
        del_pos = '0;
        hit_vol = '0;
        for (int i = 0; i < ENTRIES_N; i++) begin
            ins_pos = ins_pos + CNT_W'(i_mask_cmp[i]);
            if (i_match_sel[i]) begin
                del_pos = del_pos | IDX_W'(i);
                hit_vol = hit_vol | vols_q[i];
            end
        end
        new_vol = (i_cmd_opcode == OP_ADD) ? add_vol(hit_vol, i_cmd_volume) : i_cmd_volume;
        vld_ext = {1'b0, vld_q};
        nxt_idx = CNT_W'(idx_q) + CNT_W'(1);
    end

    always_comb begin
        vld_d        = vld_q;
        keys_d       = keys_q;
        vols_d       = vols_q;
        idx_d        = idx_q;
        rsp_vld_d    = rsp_vld_q && !rsp_hs;
        rsp_status_d = rsp_status_q;
        rsp_key_d    = rsp_key_q;
        rsp_vol_d    = rsp_vol_q;
        rsp_last_d   = rsp_last_q;
        if (state_q == S_DUMP) begin
            if (rsp_hs && !rsp_last_q) begin
                idx_d        = nxt_idx[IDX_W-1:0];
                rsp_vld_d    = 1'b1;
                rsp_status_d = ST_OK;
                rsp_key_d    = keys_q[nxt_idx[IDX_W-1:0]];
                rsp_vol_d    = vols_q[nxt_idx[IDX_W-1:0]];
                rsp_last_d   = !vld_ext[nxt_idx + CNT_W'(1)];
            end
        end else if (cmd_acc) begin
            rsp_vld_d    = 1'b1;
            rsp_status_d = ST_OK;
            rsp_key_d    = i_cmd_key;
            rsp_vol_d    = i_cmd_volume;
            rsp_last_d   = 1'b1;
            case (i_cmd_opcode)
                OP_NOP: rsp_vld_d = 1'b0;
                OP_CLR: begin
                    vld_d     = '0;
                    rsp_key_d = '0;
                    rsp_vol_d = '0;
                    for (int i = 0; i < ENTRIES_N; i++) begin
                        keys_d[i] = '0;
                        vols_d[i] = '0;
                    end
                end
                OP_ADD, OP_REP: begin
                    if (i_match_hit) begin
                        rsp_vol_d = new_vol;
                        for (int i = 0; i < ENTRIES_N; i++)
                            if (i_match_sel[i]) vols_d[i] = new_vol;
                    end else if (i_match_full) begin
                        rsp_status_d = ST_FULL;
                        rsp_vol_d    = '0;
                    end else begin
                        for (int i = 0; i < ENTRIES_N; i++) begin
                            if (CNT_W'(i) == ins_pos) begin
                                vld_d[i]  = 1'b1;
                                keys_d[i] = i_cmd_key;
                                vols_d[i] = i_cmd_volume;
                            end else if (CNT_W'(i) > ins_pos) begin
                                vld_d[i]  = vld_q[(i == 0) ? 0 : i - 1];
                                keys_d[i] = keys_q[(i == 0) ? 0 : i - 1];
                                vols_d[i] = vols_q[(i == 0) ? 0 : i - 1];
                            end
                        end
                    end
                end
                OP_DEL: begin
                    rsp_vol_d = '0;
                    if (i_match_hit) begin
                        for (int i = 0; i < ENTRIES_N; i++) begin
                            if (IDX_W'(i) >= del_pos) begin
                                vld_d[i]  = (i == ENTRIES_N - 1) ? 1'b0 : vld_q[(i == ENTRIES_N - 1) ? i : i + 1];
                                keys_d[i] = (i == ENTRIES_N - 1) ? '0 : keys_q[(i == ENTRIES_N - 1) ? i : i + 1];
                                vols_d[i] = (i == ENTRIES_N - 1) ? '0 : vols_q[(i == ENTRIES_N - 1) ? i : i + 1];
                            end
                        end
                    end else begin
                        rsp_status_d = ST_NOTFOUND;
                    end
                end
                OP_QRY: begin
                    idx_d = '0;
                    if (vld_q[0]) begin
                        rsp_key_d  = keys_q[0];
                        rsp_vol_d  = vols_q[0];
                        rsp_last_d = !vld_ext[1];
                    end else begin
                        rsp_status_d = ST_NOTFOUND;
                        rsp_key_d    = '0;
                        rsp_vol_d    = '0;
                    end
                end
                default: begin
                    rsp_status_d = ST_BADOP;
                    rsp_vol_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q        <= '0;
            idx_q        <= '0;
            rsp_vld_q    <= 1'b0;
            rsp_status_q <= '0;
            rsp_key_q    <= '0;
            rsp_vol_q    <= '0;
            rsp_last_q   <= 1'b0;
            for (int i = 0; i < ENTRIES_N; i++) begin
                keys_q[i] <= '0;
                vols_q[i] <= '0;
            end
        end else begin
            vld_q        <= vld_d;
            keys_q       <= keys_d;
            vols_q       <= vols_d;
            idx_q        <= idx_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_status_q <= rsp_status_d;
            rsp_key_q    <= rsp_key_d;
            rsp_vol_q    <= rsp_vol_d;
            rsp_last_q   <= rsp_last_d;
        end
    end

    always_comb begin
        o_stcur_keys_r    = '0;
        o_stcur_volumes_r = '0;
        for (int i = 0; i < ENTRIES_N; i++) begin
            o_stcur_keys_r[i*KEY_BITS +: KEY_BITS]          = keys_q[i];
            o_stcur_volumes_r[i*VOLUME_BITS +: VOLUME_BITS] = vols_q[i];
        end
    end

    assign o_stcur_vld_r  = vld_q;
    assign o_rsp_vld_r    = rsp_vld_q;
    assign o_rsp_status_r = rsp_status_q;
    assign o_rsp_key_r    = rsp_key_q;
    assign o_rsp_volume_r = rsp_vol_q;
    assign o_rsp_last_r   = rsp_last_q;

endmodule

// File: tb/tb_v_pipe_update_exe.sv
// Testbench for v_pipe_update_exe: constant vectors, hand sequences and randomized commands against a queue-based model.
`timescale 1ns/1ps
module tb_v_pipe_update_exe;
    localparam int N  = 16;
    localparam int KB = 32;
    localparam int VB = 32;
    localparam int CW = N * KB;
    localparam logic [1:0] OK = 2'd0, EFULL = 2'd1, ENF = 2'd2, EBAD = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cmd_vld, o_cmd_rdy;
    logic [2:0]    i_cmd_opcode;
    logic [KB-1:0] i_cmd_key;
    logic [VB-1:0] i_cmd_volume;
    logic          i_match_hit, i_match_full;
    logic [N-1:0]  i_match_sel, i_mask_cmp;
    logic [N-1:0]  o_stcur_vld_r;
    logic [N*KB-1:0] o_stcur_keys_r;
    logic [N*VB-1:0] o_stcur_volumes_r;
    logic          o_rsp_vld_r, i_rsp_rdy, o_rsp_last_r;
    logic [1:0]    o_rsp_status_r;
    logic [KB-1:0] o_rsp_key_r;
    logic [VB-1:0] o_rsp_volume_r;

    always #5 clk = ~clk;

    v_pipe_update_exe #(.ENTRIES_N(N), .KEY_BITS(KB), .VOLUME_BITS(VB), .IS_BID_TABLE(1)) dut (
        .clk(clk), .rst(rst), .i_cmd_vld(i_cmd_vld), .o_cmd_rdy(o_cmd_rdy),
        .i_cmd_opcode(i_cmd_opcode), .i_cmd_key(i_cmd_key), .i_cmd_volume(i_cmd_volume),
        .i_match_hit(i_match_hit), .i_match_full(i_match_full), .i_match_sel(i_match_sel),
        .i_mask_cmp(i_mask_cmp), .o_stcur_vld_r(o_stcur_vld_r), .o_stcur_keys_r(o_stcur_keys_r),
        .o_stcur_volumes_r(o_stcur_volumes_r), .o_rsp_vld_r(o_rsp_vld_r), .i_rsp_rdy(i_rsp_rdy),
        .o_rsp_status_r(o_rsp_status_r), .o_rsp_key_r(o_rsp_key_r), .o_rsp_volume_r(o_rsp_volume_r),
        .o_rsp_last_r(o_rsp_last_r));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference table: best (highest key) first.
    logic [KB-1:0] m_key[$];
    logic [VB-1:0] m_vol[$];

    typedef struct {
        logic [2:0]    op;
        logic [KB-1:0] key;
        logic [VB-1:0] vol;
        logic [1:0]    st;
        logic [VB-1:0] evol;
        logic [N-1:0]  evld;
        logic [KB-1:0] ek0;
        logic [KB-1:0] ek1;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VB-1:0] m_add(input logic [VB-1:0] a, input logic [VB-1:0] b);
        longint unsigned s;
        s = 64'(a) + 64'(b);
`ifdef V_PIPE_UPDATE_EXE_SAT_EN
        if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`endif
        return VB'(s % 64'h1_0000_0000);
    endfunction

    // Plays the role of the upstream compare stage.
    task automatic drive_match(input logic [KB-1:0] key);
        i_match_hit  = 1'b0;
        i_match_sel  = '0;
        i_mask_cmp   = '0;
        i_match_full = (m_key.size() == N);
        foreach (m_key[i]) begin
            if (m_key[i] == key) begin
                i_match_hit    = 1'b1;
                i_match_sel[i] = 1'b1;
            end
            if (m_key[i] >= key) i_mask_cmp[i] = 1'b1;
        end
    endtask

    task automatic model_cmd(input logic [2:0] op, input logic [KB-1:0] key, input logic [VB-1:0] vol,
                             output logic has, output logic [1:0] st, output logic [VB-1:0] rv);
        int pos = -1;
        int p = 0;
        foreach (m_key[i]) if (m_key[i] == key) pos = i;
        has = 1'b1; st = OK; rv = vol;
        case (op)
            3'd0: has = 1'b0;
            3'd1: begin m_key.delete(); m_vol.delete(); rv = '0; end
            3'd2, 3'd4: begin
                if (pos >= 0) begin
                    rv = (op == 3'd2) ? m_add(m_vol[pos], vol) : vol;
                    m_vol[pos] = rv;
                end else if (m_key.size() == N) begin
                    st = EFULL;
                end else begin
                    foreach (m_key[i]) if (m_key[i] > key) p++;
                    m_key.insert(p, key);
                    m_vol.insert(p, vol);
                end
            end
            3'd3: begin
                rv = '0;
                if (pos >= 0) begin m_key.delete(pos); m_vol.delete(pos); end
                else st = ENF;
            end
            default: st = EBAD;
        endcase
    endtask

    task automatic chk_state(input string tag);
        logic [N-1:0]  ev = '0;
        logic [CW-1:0] ek = '0;
        logic [CW-1:0] evv = '0;
        foreach (m_key[i]) begin
            ev[i] = 1'b1;
            ek[i*KB +: KB]  = m_key[i];
            evv[i*VB +: VB] = m_vol[i];
        end
        chk({tag, " vld"}, CW'(o_stcur_vld_r), CW'(ev));
        chk({tag, " keys"}, o_stcur_keys_r, ek);
        chk({tag, " vols"}, o_stcur_volumes_r, evv);
    endtask

    task automatic check_dump(input int stall);
        int k = m_key.size();
        if (k == 0) begin
            chk("qry_empty vld", CW'(o_rsp_vld_r), CW'(1));
            chk("qry_empty status", CW'(o_rsp_status_r), CW'(ENF));
            chk("qry_empty key", CW'(o_rsp_key_r), CW'(0));
            chk("qry_empty vol", CW'(o_rsp_volume_r), CW'(0));
            chk("qry_empty last", CW'(o_rsp_last_r), CW'(1));
            return;
        end
        for (int j = 0; j < k; j++) begin
            chk("dump vld", CW'(o_rsp_vld_r), CW'(1));
            chk("dump status", CW'(o_rsp_status_r), CW'(OK));
            chk("dump key", CW'(o_rsp_key_r), CW'(m_key[j]));
            chk("dump vol", CW'(o_rsp_volume_r), CW'(m_vol[j]));
            chk("dump last", CW'(o_rsp_last_r), CW'(j == k - 1));
            chk("dump cmd_rdy", CW'(o_cmd_rdy), CW'(0));
            if (j == 0 && stall > 0) begin
                i_rsp_rdy = 1'b0;
                repeat (stall) begin
                    @(posedge clk); #1;
                    chk("dump hold vld", CW'(o_rsp_vld_r), CW'(1));
                    chk("dump hold key", CW'(o_rsp_key_r), CW'(m_key[0]));
                    chk("dump hold cmd_rdy", CW'(o_cmd_rdy), CW'(0));
                end
                i_rsp_rdy = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("dump end vld", CW'(o_rsp_vld_r), CW'(0));
        chk("dump end cmd_rdy", CW'(o_cmd_rdy), CW'(1));
        chk_state("dump");
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [KB-1:0] key, input logic [VB-1:0] vol, input int stall);
        logic has;
        logic [1:0] st;
        logic [VB-1:0] rv;
        int t = 0;
        drive_match(key);
        i_cmd_vld = 1'b1; i_cmd_opcode = op; i_cmd_key = key; i_cmd_volume = vol;
        while (!o_cmd_rdy && t < 50) begin @(posedge clk); #1; t++; end
        chk("cmd_rdy", CW'(o_cmd_rdy), CW'(1));
        @(posedge clk); #1;
        i_cmd_vld = 1'b0;
        if (op == 3'd5) begin
            check_dump(stall);
            return;
        end
        model_cmd(op, key, vol, has, st, rv);
        chk("rsp_vld", CW'(o_rsp_vld_r), CW'(has));
        if (has) begin
            chk("rsp status", CW'(o_rsp_status_r), CW'(st));
            chk("rsp key", CW'(o_rsp_key_r), CW'((op == 3'd1) ? '0 : key));
            chk("rsp last", CW'(o_rsp_last_r), CW'(1));
            if (st == OK) chk("rsp vol", CW'(o_rsp_volume_r), CW'(rv));
        end
        chk_state("cmd");
        if (has && stall > 0) begin
            i_rsp_rdy = 1'b0;
            chk("stall cmd_rdy", CW'(o_cmd_rdy), CW'(0));
            @(posedge clk); #1;
            chk("stall vld", CW'(o_rsp_vld_r), CW'(1));
            chk("stall status", CW'(o_rsp_status_r), CW'(st));
            i_rsp_rdy = 1'b1;
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{3'd2, 100, 5, OK, 5, 16'h0001, 100, 0};
        vt[1] = '{3'd2, 200, 7, OK, 7, 16'h0003, 200, 100};
        vt[2] = '{3'd2, 300, 1, OK, 1, 16'h0007, 300, 200};
        vt[3] = '{3'd3, 200, 0, OK, 0, 16'h0003, 300, 100};
        vt[4] = '{3'd3, 999, 0, ENF, 0, 16'h0003, 300, 100};
        vt[5] = '{3'd4, 100, 9, OK, 9, 16'h0003, 300, 100};
        vt[6] = '{3'd2, 100, 2, OK, 11, 16'h0003, 300, 100};
        vt[7] = '{3'd4, 50, 4, OK, 4, 16'h0007, 300, 100};
        vt[8] = '{3'd6, 1, 0, EBAD, 0, 16'h0007, 300, 100};
        vt[9] = '{3'd1, 0, 0, OK, 0, 16'h0000, 0, 0};

        rst = 1'b1; i_cmd_vld = 1'b0; i_cmd_opcode = '0; i_cmd_key = '0; i_cmd_volume = '0;
        i_match_hit = 1'b0; i_match_full = 1'b0; i_match_sel = '0; i_mask_cmp = '0; i_rsp_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset cmd_rdy", CW'(o_cmd_rdy), CW'(0));
        chk("reset rsp_vld", CW'(o_rsp_vld_r), CW'(0));
        chk("reset status", CW'(o_rsp_status_r), CW'(0));
        chk("reset key", CW'(o_rsp_key_r), CW'(0));
        chk("reset last", CW'(o_rsp_last_r), CW'(0));
        chk("reset vld", CW'(o_stcur_vld_r), CW'(0));
        chk("reset keys", o_stcur_keys_r, '0);
        rst = 1'b0;
        #1;
        chk("post-reset cmd_rdy", CW'(o_cmd_rdy), CW'(1));

        for (int v = 0; v < 10; v++) begin
            do_cmd(vt[v].op, vt[v].key, vt[v].vol, 0);
            chk("vec status", CW'(o_rsp_status_r), CW'(vt[v].st));
            if (vt[v].st == OK) chk("vec vol", CW'(o_rsp_volume_r), CW'(vt[v].evol));
            chk("vec vld", CW'(o_stcur_vld_r), CW'(vt[v].evld));
            chk("vec key0", CW'(o_stcur_keys_r[0 +: KB]), CW'(vt[v].ek0));
            chk("vec key1", CW'(o_stcur_keys_r[KB +: KB]), CW'(vt[v].ek1));
        end

        // Full table corner cases.
        for (int i = 0; i < N; i++) do_cmd(3'd2, KB'((i + 1) * 1000), VB'(i + 1), 0);
        chk("full vld", CW'(o_stcur_vld_r), CW'(16'hFFFF));
        do_cmd(3'd2, 555, 1, 0);
        chk("full add status", CW'(o_rsp_status_r), CW'(EFULL));
        do_cmd(3'd2, 3000, 3, 0);
        chk("full hit status", CW'(o_rsp_status_r), CW'(OK));
        chk("full hit vol", CW'(o_rsp_volume_r), CW'(6));

        // Volume overflow on ADD hit.
        do_cmd(3'd1, 0, 0, 0);
        do_cmd(3'd2, 77, 32'hFFFF_FFFF, 0);
        do_cmd(3'd2, 77, 2, 0);
`ifdef V_PIPE_UPDATE_EXE_SAT_EN
        chk("sat vol", CW'(o_rsp_volume_r), CW'(32'hFFFF_FFFF));
`else
        chk("wrap vol", CW'(o_rsp_volume_r), CW'(32'h0000_0001));
`endif

        // Dump of three entries with two stalled cycles on the first beat.
        do_cmd(3'd1, 0, 0, 0);
        do_cmd(3'd2, 10, 1, 0);
        do_cmd(3'd2, 20, 2, 0);
        do_cmd(3'd2, 30, 3, 0);
        do_cmd(3'd5, 0, 0, 2);
        do_cmd(3'd1, 0, 0, 0);
        do_cmd(3'd5, 0, 0, 0);

        // Reset during beat 1 of a 4-entry dump.
        for (int i = 0; i < 4; i++) do_cmd(3'd2, KB'(40 + i), VB'(i), 0);
        drive_match(0);
        i_cmd_vld = 1'b1; i_cmd_opcode = 3'd5;
        @(posedge clk); #1;
        i_cmd_vld = 1'b0;
        chk("rstdump beat0 key", CW'(o_rsp_key_r), CW'(43));
        @(posedge clk); #1;
        chk("rstdump beat1 key", CW'(o_rsp_key_r), CW'(42));
        chk("rstdump beat1 last", CW'(o_rsp_last_r), CW'(0));
        rst = 1'b1;
        #1;
        chk("rstdump cmd_rdy in rst", CW'(o_cmd_rdy), CW'(0));
        @(posedge clk); #1;
        chk("rstdump rsp_vld", CW'(o_rsp_vld_r), CW'(0));
        chk("rstdump vld", CW'(o_stcur_vld_r), CW'(0));
        rst = 1'b0;
        m_key.delete(); m_vol.delete();
        #1;
        chk("rstdump cmd_rdy", CW'(o_cmd_rdy), CW'(1));
        @(posedge clk); #1;
        chk("rstdump no beat", CW'(o_rsp_vld_r), CW'(0));
        do_cmd(3'd7, 123, 0, 0);
        chk("badop status", CW'(o_rsp_status_r), CW'(EBAD));

        // Randomized command stream.
        for (int it = 0; it < 400; it++) begin
            int r = $urandom_range(0, 99);
            logic [2:0] op;
            logic [KB-1:0] key = KB'($urandom_range(1, 24) * 5);
            logic [VB-1:0] vol = ($urandom_range(0, 7) == 0) ? VB'(32'hFFFF_FFF0 + $urandom_range(0, 15))
                                                              : VB'($urandom_range(0, 1000));
            if (r < 40)      op = 3'd2;
            else if (r < 55) op = 3'd3;
            else if (r < 70) op = 3'd4;
            else if (r < 78) op = 3'd5;
            else if (r < 83) op = 3'd0;
            else if (r < 86) op = 3'd1;
            else if (r < 90) op = ($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7;
            else             op = 3'd2;
            do_cmd(op, key, vol, (op == 3'd5) ? $urandom_range(0, 2) : int'($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
